pwm_duty_sequencer: RTL and testbench
=====================================

Name: pwm_duty_sequencer

Overview:
Controller that owns the duty-cycle register of a PWM generator and sequences its changes. It takes two raw push-buttons (increase/decrease), synchronises and debounces them, and maintains a saturating target duty. It slews the applied duty toward the target one step per RAMP_DIV PWM periods (soft ramp). Duty updates occur only on PWM period boundaries, so no output pulse is ever truncated or stretched mid-period.

Parameters:
PERIOD, 10, PWM period in clocks; duty range 0..PERIOD
DW, 4, width of duty/counter fields; must satisfy 2^DW > PERIOD
DUTY_INIT, 5, reset value of target and applied duty
DEB_DIV, 4, clocks per debounce sample tick (kept small for sim; silicon build overrides)
RAMP_DIV, 2, PWM periods per one-step duty change

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  block enable; low freezes all counters and state
inc_btn  in  1  raw increase button, asynchronous
dec_btn  in  1  raw decrease button, asynchronous
pwm_out  out  1  PWM output
duty_cur  out  DW  currently applied duty
duty_tgt  out  DW  target duty
busy  out  1  high while ramping (state != HOLD)
period_end  out  1  one-cycle pulse on last clock of each PWM period

Behaviour:
- Reset (async, rst_n=0): duty_cur=duty_tgt=DUTY_INIT; state HOLD; pwm_cnt, deb_cnt, ramp_cnt = 0; all sync/debounce flops 0; busy=0; period_end=0.
- Sync: each button passes through a 2-FF synchroniser every clock, independent of ena.
- Debounce: deb_cnt counts 0..DEB_DIV-1 while ena=1. deb_tick fires when deb_cnt==DEB_DIV-1. On deb_tick, sampled level shifts into s1, then s1 into s2. Press event = deb_tick & s1 & ~s2, a single-cycle pulse. A held button produces exactly one event.
- Target update, registered on the cycle after the event:
  - inc only: duty_tgt = min(duty_tgt+1, PERIOD).
  - dec only: duty_tgt = max(duty_tgt-1, 0).
  - Both in the same cycle: no change.
  - No wrap at either end.
- PWM counter: pwm_cnt counts 0..PERIOD-1 and wraps. period_end = ena & (pwm_cnt==PERIOD-1).
- pwm_out = ena & (pwm_cnt < duty_cur), decoded from flops only.
  - duty 0 gives constant 0.
  - duty PERIOD gives constant 1.
- FSM states: HOLD, RAMP_UP, RAMP_DOWN. Next state is evaluated every enabled cycle from the registered duty_tgt vs duty_cur:
  - tgt > cur: RAMP_UP.
  - tgt < cur: RAMP_DOWN.
  - equal: HOLD.
  - Direct RAMP_UP<->RAMP_DOWN is allowed when the target reverses mid-ramp; ramp_cnt is not cleared on reversal.
- Ramp timing: in a RAMP state, ramp_cnt increments on each period_end. On the period_end where ramp_cnt==RAMP_DIV-1:
  - duty_cur steps ±1 toward the target.
  - ramp_cnt returns to 0.
  - The new duty takes effect from pwm_cnt=0 of the next period.
  - Entering HOLD clears ramp_cnt.
- ena=0: pwm_cnt, deb_cnt, ramp_cnt, s1/s2, duty registers and state all hold; pwm_out=0; no events. Resuming continues from the held values.
- Outputs duty_cur, duty_tgt and busy are direct flop outputs.

Test Plan:
1. Reset then ena=1, no buttons → pwm_out high for 5 of every 10 clocks; period_end every 10th clock; busy=0; duty_cur=duty_tgt=5.
2. Hold inc_btn for 40 clocks → exactly one event; duty_tgt 5→6. busy rises; duty_cur becomes 6 at the second period_end after busy rises; pwm_out then high 6/10; busy falls.
3. Three separate inc presses in quick succession (target 8) → duty_cur 5→6→7→8, each step 20 clocks apart, applied only at period boundaries. No period shows a high time other than the old or new duty.
4. Press inc 7 times from 5 → duty_tgt saturates at 10; duty_cur ramps to 10 and pwm_out stays constant 1. Then 12 dec presses → duty_tgt saturates at 0; duty_cur ramps to 0 and pwm_out stays constant 0.
5. Press inc and dec simultaneously (identical waveforms) → duty_tgt unchanged, busy stays 0. Then target 9 with a dec press mid-ramp at duty_cur 7 (tgt 8) → duty_cur settles at 8 without overshoot beyond 8.
6. Deassert ena mid-ramp for 30 clocks → pwm_out=0 and all counters frozen; resume reproduces the remaining sequence. Assert rst_n=0 mid-ramp → immediate return to duty 5, HOLD, busy=0 without waiting for clk.

Source files
------------

// File: rtl/pwm_duty_sequencer.sv
// PWM duty-cycle sequencer: debounced inc/dec buttons set a saturating target,
// and the applied duty slews toward it one step per RAMP_DIV periods, only at period boundaries.
module pwm_duty_sequencer #(
  parameter int unsigned PERIOD    = 10,
  parameter int unsigned DW        = 4,
  parameter int unsigned DUTY_INIT = 5,
  parameter int unsigned DEB_DIV   = 4,
  parameter int unsigned RAMP_DIV  = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena_i,
  input  logic          inc_btn_i,
  input  logic          dec_btn_i,
  output logic          pwm_out_o,
  output logic [DW-1:0] duty_cur_o,
  output logic [DW-1:0] duty_tgt_o,
  output logic          busy_o,
  output logic          period_end_o
);

  localparam int unsigned DEB_W  = (DEB_DIV  > 1) ? $clog2(DEB_DIV)  : 1;
  localparam int unsigned RAMP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  localparam logic [DW-1:0]     DUTY_MAX  = DW'(PERIOD);
  localparam logic [DW-1:0]     PWM_LAST  = DW'(PERIOD - 1);
  localparam logic [DW-1:0]     DUTY_RST  = DW'(DUTY_INIT);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_DIV - 1);
  localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_DIV - 1);

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } state_e;

  logic              inc_meta_q, inc_sync_q, dec_meta_q, dec_sync_q;
  logic              inc_s1_q, inc_s1_d, inc_s2_q, inc_s2_d;
  logic              dec_s1_q, dec_s1_d, dec_s2_q, dec_s2_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [DW-1:0]     pwm_cnt_q, pwm_cnt_d;
  logic [RAMP_W-1:0] ramp_cnt_q, ramp_cnt_d;
  logic [DW-1:0]     duty_cur_q, duty_cur_d;
  logic [DW-1:0]     duty_tgt_q, duty_tgt_d;
  state_e            state_q, state_d;
  logic              busy_q, busy_d;

  logic deb_tick_c, inc_evt_c, dec_evt_c, period_end_c;

  assign deb_tick_c   = ena_i & (deb_cnt_q == DEB_LAST);
  assign inc_evt_c    = deb_tick_c & inc_s1_q & ~inc_s2_q;
  assign dec_evt_c    = deb_tick_c & dec_s1_q & ~dec_s2_q;
  assign period_end_c = ena_i & (pwm_cnt_q == PWM_LAST);

  // Next-state for debounce, target, PWM counter, FSM and ramp; everything holds when disabled
  always_comb begin
    inc_s1_d   = inc_s1_q;
    inc_s2_d   = inc_s2_q;
    dec_s1_d   = dec_s1_q;
    dec_s2_d   = dec_s2_q;
    deb_cnt_d  = deb_cnt_q;
    pwm_cnt_d  = pwm_cnt_q;
    ramp_cnt_d = ramp_cnt_q;
    duty_cur_d = duty_cur_q;
    duty_tgt_d = duty_tgt_q;
    state_d    = state_q;

    if (ena_i) begin
      deb_cnt_d = deb_tick_c ? '0 : deb_cnt_q + DEB_W'(1);
      pwm_cnt_d = (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + DW'(1);

      if (deb_tick_c) begin
        inc_s1_d = inc_sync_q;
        inc_s2_d = inc_s1_q;
        dec_s1_d = dec_sync_q;
        dec_s2_d = dec_s1_q;
      end

      // Simultaneous inc and dec cancel; both ends saturate
      if (inc_evt_c && !dec_evt_c && (duty_tgt_q < DUTY_MAX)) begin
        duty_tgt_d = duty_tgt_q + DW'(1);
      end else if (dec_evt_c && !inc_evt_c && (duty_tgt_q != '0)) begin
        duty_tgt_d = duty_tgt_q - DW'(1);
      end

      if (duty_tgt_q > duty_cur_q) begin
        state_d = RAMP_UP;
      end else if (duty_tgt_q < duty_cur_q) begin
        state_d = RAMP_DOWN;
      end else begin
        state_d = HOLD;
      end

      // Ramp counter survives a direction reversal; only HOLD clears it
      if (state_d == HOLD) begin
        ramp_cnt_d = '0;
      end else if ((state_q != HOLD) && period_end_c) begin
        if (ramp_cnt_q == RAMP_LAST) begin
          ramp_cnt_d = '0;
          if (duty_tgt_q > duty_cur_q) begin
            duty_cur_d = duty_cur_q + DW'(1);
          end else if (duty_tgt_q < duty_cur_q) begin
            duty_cur_d = duty_cur_q - DW'(1);
          end
        end else begin
          ramp_cnt_d = ramp_cnt_q + RAMP_W'(1);
        end
      end
    end

    busy_d = (state_d != HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_meta_q <= 1'b0;
      inc_sync_q <= 1'b0;
      dec_meta_q <= 1'b0;
      dec_sync_q <= 1'b0;
      inc_s1_q   <= 1'b0;
      inc_s2_q   <= 1'b0;
      dec_s1_q   <= 1'b0;
      dec_s2_q   <= 1'b0;
      deb_cnt_q  <= '0;
      pwm_cnt_q  <= '0;
      ramp_cnt_q <= '0;
      duty_cur_q <= DUTY_RST;
      duty_tgt_q <= DUTY_RST;
      state_q    <= HOLD;
      busy_q     <= 1'b0;
    end else begin
      inc_meta_q <= inc_btn_i;
      inc_sync_q <= inc_meta_q;
      dec_meta_q <= dec_btn_i;
      dec_sync_q <= dec_meta_q;
      inc_s1_q   <= inc_s1_d;
      inc_s2_q   <= inc_s2_d;
      dec_s1_q   <= dec_s1_d;
      dec_s2_q   <= dec_s2_d;
      deb_cnt_q  <= deb_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      ramp_cnt_q <= ramp_cnt_d;
      duty_cur_q <= duty_cur_d;
      duty_tgt_q <= duty_tgt_d;
      state_q    <= state_d;
      busy_q     <= busy_d;
    end
  end

  assign pwm_out_o    = ena_i & (pwm_cnt_q < duty_cur_q);
  assign period_end_o = period_end_c;
  assign duty_cur_o   = duty_cur_q;
  assign duty_tgt_o   = duty_tgt_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Scoreboard bench: stimulus queues expected target/duty steps; a monitor checks
// every duty change, step spacing, and each PWM period's length and high time.
module tb_pwm_duty_sequencer;

  localparam int unsigned PERIOD    = 10;
  localparam int unsigned DW        = 4;
  localparam int unsigned DUTY_INIT = 5;
  localparam int unsigned DEB_DIV   = 4;
  localparam int unsigned RAMP_DIV  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b0;
  logic          inc_btn = 1'b0;
  logic          dec_btn = 1'b0;
  logic          pwm_out, busy, period_end;
  logic [DW-1:0] duty_cur, duty_tgt;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] exp_tgt_q[$];
  logic [DW-1:0] exp_cur_q[$];

  logic [DW-1:0] prev_cur, prev_tgt, exp_cur;
  int            pe_cnt, hi_cnt, len_cnt;

  always #5 clk = ~clk;

  pwm_duty_sequencer #(
    .PERIOD   (PERIOD),
    .DW       (DW),
    .DUTY_INIT(DUTY_INIT),
    .DEB_DIV  (DEB_DIV),
    .RAMP_DIV (RAMP_DIV)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena_i       (ena),
    .inc_btn_i   (inc_btn),
    .dec_btn_i   (dec_btn),
    .pwm_out_o   (pwm_out),
    .duty_cur_o  (duty_cur),
    .duty_tgt_o  (duty_tgt),
    .busy_o      (busy),
    .period_end_o(period_end)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a new target or duty
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_cur = DW'(DUTY_INIT);
        prev_tgt = DW'(DUTY_INIT);
        exp_cur  = DW'(DUTY_INIT);
        pe_cnt   = 0;
        hi_cnt   = 0;
        len_cnt  = 0;
      end else begin
        if (duty_tgt !== prev_tgt) begin
          if (exp_tgt_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tgt_unexpected: got %0d expected no change from %0d at %0t",
                     duty_tgt, prev_tgt, $time);
          end else begin
            check("tgt_step", duty_tgt, exp_tgt_q.pop_front());
          end
          prev_tgt = duty_tgt;
        end
        if (duty_cur !== prev_cur) begin
          if (exp_cur_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL cur_unexpected: got %0d expected no change from %0d at %0t",
                     duty_cur, prev_cur, $time);
          end else begin
            exp_cur = exp_cur_q.pop_front();
            check("cur_step", duty_cur, exp_cur);
            check("ramp_gap", pe_cnt, RAMP_DIV);
          end
          prev_cur = duty_cur;
          pe_cnt   = 0;
        end
        if (busy !== 1'b1) pe_cnt = 0;
        else if (period_end === 1'b1) pe_cnt++;
        if (ena) begin
          len_cnt++;
          if (pwm_out === 1'b1) hi_cnt++;
        end else begin
          check("pwm_idle", pwm_out, 0);
          check("pe_idle", period_end, 0);
        end
        if (period_end === 1'b1) begin
          check("period_len", len_cnt, PERIOD);
          check("high_time", hi_cnt, exp_cur);
          len_cnt = 0;
          hi_cnt  = 0;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic inc, input logic dec, input int hi, input int lo);
    step();
    inc_btn = inc;
    dec_btn = dec;
    repeat (hi) step();
    inc_btn = 1'b0;
    dec_btn = 1'b0;
    repeat (lo) step();
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    exp_tgt_q.delete();
    exp_cur_q.delete();
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic settle(input int max_cyc);
    int n = 0;
    while ((busy !== 1'b0 || exp_cur_q.size() != 0 || exp_tgt_q.size() != 0) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("settle_in_time", (n < max_cyc), 1);
  endtask

  task automatic wait_cur(input logic [DW-1:0] v, input int max_cyc);
    int n = 0;
    @(negedge clk);
    while (duty_cur !== v && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("wait_cur_reached", (n < max_cyc), 1);
  endtask

  initial begin
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) step();
    @(negedge clk);
    check("rst_cur", duty_cur, 5);
    check("rst_tgt", duty_tgt, 5);
    check("rst_busy", busy, 0);
    check("rst_pwm", pwm_out, 0);
    check("rst_pe", period_end, 0);
    step();
    rst_n = 1'b1;
    ena   = 1'b1;

    // Idle at duty 5, then simultaneous inc+dec must not move the target
    repeat (40) step();
    press(1'b1, 1'b1, 16, 16);
    @(negedge clk);
    check("both_tgt", duty_tgt, 5);
    check("both_busy", busy, 0);

    // Held inc gives exactly one step
    exp_tgt_q.push_back(4'd6);
    exp_cur_q.push_back(4'd6);
    press(1'b1, 1'b0, 40, 20);
    settle(200);

    // Three quick presses from 5 to 8
    do_reset();
    for (int i = 6; i <= 8; i++) begin
      exp_tgt_q.push_back(DW'(i));
      exp_cur_q.push_back(DW'(i));
    end
    repeat (3) press(1'b1, 1'b0, 16, 16);
    settle(400);

    // Saturate high then low
    do_reset();
    for (int i = 6; i <= 10; i++) begin
      exp_tgt_q.push_back(DW'(i));
      exp_cur_q.push_back(DW'(i));
    end
    repeat (7) press(1'b1, 1'b0, 16, 16);
    settle(400);
    repeat (30) step();
    for (int i = 9; i >= 0; i--) begin
      exp_tgt_q.push_back(DW'(i));
      exp_cur_q.push_back(DW'(i));
    end
    repeat (12) press(1'b0, 1'b1, 16, 16);
    settle(600);
    repeat (30) step();
    @(negedge clk);
    check("sat_low_tgt", duty_tgt, 0);

    // Target 9 from 0, then dec to 8 while duty is at 7: settles at 8
    for (int i = 1; i <= 9; i++) exp_tgt_q.push_back(DW'(i));
    for (int i = 1; i <= 8; i++) exp_cur_q.push_back(DW'(i));
    repeat (9) press(1'b1, 1'b0, 8, 8);
    wait_cur(4'd7, 100);
    exp_tgt_q.push_back(4'd8);
    press(1'b0, 1'b1, 8, 8);
    settle(300);
    repeat (30) step();
    @(negedge clk);
    check("no_overshoot_cur", duty_cur, 8);
    check("no_overshoot_tgt", duty_tgt, 8);

    // Freeze mid-ramp with ena low, then resume
    do_reset();
    for (int i = 6; i <= 8; i++) begin
      exp_tgt_q.push_back(DW'(i));
      exp_cur_q.push_back(DW'(i));
    end
    repeat (3) press(1'b1, 1'b0, 8, 8);
    ena = 1'b0;
    repeat (30) step();
    @(negedge clk);
    check("frozen_busy", busy, 1);
    step();
    ena = 1'b1;
    settle(300);

    // Asynchronous reset mid-ramp
    exp_tgt_q.push_back(4'd9);
    exp_tgt_q.push_back(4'd10);
    exp_cur_q.push_back(4'd9);
    repeat (2) press(1'b1, 1'b0, 8, 8);
    wait_cur(4'd9, 100);
    check("mid_busy", busy, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_tgt_q.delete();
    exp_cur_q.delete();
    #1;
    check("arst_cur", duty_cur, 5);
    check("arst_tgt", duty_tgt, 5);
    check("arst_busy", busy, 0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (40) step();

    check("tgt_queue_empty", exp_tgt_q.size(), 0);
    check("cur_queue_empty", exp_cur_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
